rotator_rr_scheduler: RTL and testbench

// Shares one barrelShifterRight rotator datapath among NUM_REQ requesters. Each

---
 rtl/rotator_rr_scheduler_pkg.sv | 28 ++
 rtl/rotator_rr_scheduler_if.sv | 29 ++
 rtl/rotator_rr_scheduler_rotator.sv | 26 ++
 rtl/rotator_rr_scheduler_rr_arbiter.sv | 30 +++
 rtl/rotator_rr_scheduler.sv | 118 +++++++++++
 tb/tb_rotator_rr_scheduler.sv | 197 +++++++++++++++++++
 6 files changed

// File: rtl/rotator_rr_scheduler_pkg.sv
// Shared types and the round-robin selection function for the rotator scheduler.
package rotator_rr_scheduler_pkg;

  localparam int unsigned MAX_REQ = 32;
  localparam int unsigned MAX_IDW = $clog2(MAX_REQ);

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // First valid index after ptr, wrapping modulo num_req; -1 when nothing is valid.
  function automatic int rr_next(input int ptr, input logic [MAX_REQ-1:0] valids,
                                 input int num_req);
    int idx;
    int found;
    found = -1;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= num_req) begin
        idx = ptr + k;
        if (idx >= num_req) idx = idx - num_req;
        if (valids[MAX_IDW'(idx)]) found = idx;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/rotator_rr_scheduler_if.sv
// Requester and result handshake bundle for the shared rotator.
interface rotator_rr_scheduler_if #(
  parameter int unsigned WIDTH              = 32,
  parameter int unsigned SHIFTBITS_PER_STEP = 1,
  parameter int unsigned NUM_REQ            = 4
);
  localparam int unsigned ROTW = $clog2(WIDTH / SHIFTBITS_PER_STEP);
  localparam int unsigned IDW  = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            reqValid;
  logic [NUM_REQ-1:0]            reqReady;
  logic [NUM_REQ-1:0][WIDTH-1:0] reqData;
  logic [NUM_REQ-1:0][ROTW-1:0]  reqRot;
  logic                          outValid;
  logic                          outReady;
  logic [WIDTH-1:0]              outData;
  logic [IDW-1:0]                outId;

  modport master (
    output reqValid, reqData, reqRot, outReady,
    input  reqReady, outValid, outData, outId
  );

  modport slave (
    input  reqValid, reqData, reqRot, outReady,
    output reqReady, outValid, outData, outId
  );

endinterface

// File: rtl/rotator_rr_scheduler_rotator.sv
// Log-depth barrel rotator: rotate right by rot_amt units of SHIFTBITS_PER_STEP bits.
module rotator_rr_scheduler_rotator #(
  parameter int unsigned WIDTH              = 32,
  parameter int unsigned SHIFTBITS_PER_STEP = 1
) (
  input  logic [WIDTH-1:0]                               data_in,
  input  logic [$clog2(WIDTH / SHIFTBITS_PER_STEP)-1:0]  rot_amt,
  output logic [WIDTH-1:0]                               data_out_c
);
  localparam int unsigned ROTW = $clog2(WIDTH / SHIFTBITS_PER_STEP);

  logic [WIDTH-1:0] stage_c [ROTW+1];

  assign stage_c[0] = data_in;

  // Stage s conditionally rotates by 2^s units; bit j takes bit (j+amt) mod WIDTH.
  for (genvar s = 0; s < ROTW; s++) begin : g_stage
    localparam int unsigned AMT = (2 ** s) * SHIFTBITS_PER_STEP;
    assign stage_c[s+1] = rot_amt[s]
                        ? {stage_c[s][AMT-1:0], stage_c[s][WIDTH-1:AMT]}
                        : stage_c[s];
  end

  assign data_out_c = stage_c[ROTW];

endmodule

// File: rtl/rotator_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first valid requester after rr_ptr.
module rotator_rr_scheduler_rr_arbiter
  import rotator_rr_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  input  logic                       enable,
  output logic [NUM_REQ-1:0]         grant_c,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_c,
  output logic                       winner_c
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("rr_arbiter: NUM_REQ out of supported range");
  end

  int win_c;

  always_comb begin
    grant_c     = '0;
    win_c       = rr_next(int'(rr_ptr), MAX_REQ'(req_valid), int'(NUM_REQ));
    winner_c    = (win_c >= 0);
    grant_idx_c = winner_c ? IDW'(win_c) : '0;
    if (winner_c && enable) grant_c[grant_idx_c] = 1'b1;
  end

endmodule

// File: rtl/rotator_rr_scheduler.sv
// Shares one rotator among NUM_REQ requesters via round-robin grant and a
// registered valid/ready result stage.
module rotator_rr_scheduler
  import rotator_rr_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH              = 32,
  parameter int unsigned SHIFTBITS_PER_STEP = 1,
  parameter int unsigned NUM_REQ            = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  rotator_rr_scheduler_if.slave bus
);
  localparam int unsigned STEPS = WIDTH / SHIFTBITS_PER_STEP;
  localparam int unsigned ROTW  = $clog2(STEPS);
  localparam int unsigned IDW   = $clog2(NUM_REQ);

  typedef logic [ROTW-1:0] rot_amt_t;
  typedef logic [IDW-1:0]  req_id_t;

  if ((WIDTH % SHIFTBITS_PER_STEP) != 0 || STEPS < 2 || (2 ** ROTW) != STEPS)
  begin : g_bad_geometry
    $error("rotator_rr_scheduler: WIDTH/SHIFTBITS_PER_STEP must be a power of 2 >= 2");
  end

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  req_id_t          out_id_q, out_id_d;
  req_id_t          rr_ptr_q, rr_ptr_d;

  logic             can_accept_c;
  logic             transfer_c;
  logic [NUM_REQ-1:0] grant_c;
  req_id_t          grant_idx_c;
  logic             winner_c;
  logic [WIDTH-1:0] op_data_c;
  rot_amt_t         op_rot_c;
  logic [WIDTH-1:0] rot_result_c;

  // Grants are suppressed while reset is held so reqReady reads all-0.
  assign can_accept_c = (state_q == OUT_EMPTY) || bus.outReady;

  rotator_rr_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_valid   (bus.reqValid),
    .rr_ptr      (rr_ptr_q),
    .enable      (can_accept_c && rst_n),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .winner_c    (winner_c)
  );

  assign transfer_c = winner_c && can_accept_c && rst_n;

  always_comb begin
    op_data_c = bus.reqData[grant_idx_c];
    op_rot_c  = bus.reqRot[grant_idx_c];
  end

  rotator_rr_scheduler_rotator #(
    .WIDTH              (WIDTH),
    .SHIFTBITS_PER_STEP (SHIFTBITS_PER_STEP)
  ) u_barrel_shifter_right (
    .data_in    (op_data_c),
    .rot_amt    (op_rot_c),
    .data_out_c (rot_result_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OUT_EMPTY;
      out_data_q <= '0;
      out_id_q   <= '0;
      rr_ptr_q   <= IDW'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Output stage: reload on transfer (even while draining), empty on drain without winner.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      OUT_EMPTY: begin
        if (transfer_c) state_d = OUT_FULL;
      end
      OUT_FULL: begin
        if (transfer_c)        state_d = OUT_FULL;
        else if (bus.outReady) state_d = OUT_EMPTY;
      end
      default: state_d = OUT_EMPTY;
    endcase
    if (transfer_c) begin
      out_data_d = rot_result_c;
      out_id_d   = grant_idx_c;
      rr_ptr_d   = grant_idx_c;
    end
  end

  assign bus.reqReady = grant_c;
  assign bus.outValid = (state_q == OUT_FULL);
  assign bus.outData  = out_data_q;
  assign bus.outId    = out_id_q;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.reqReady));

  a_hold_on_stall: assert property (@(posedge clk) disable iff (!rst_n)
    bus.outValid && !bus.outReady |=> $stable({bus.outData, bus.outId}));

endmodule

// File: tb/tb_rotator_rr_scheduler.sv
// Directed testbench for rotator_rr_scheduler (WIDTH=8, 1 bit/step, 3 requesters).
module tb_rotator_rr_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rotator_rr_scheduler_if #(
    .WIDTH(8), .SHIFTBITS_PER_STEP(1), .NUM_REQ(3)
  ) bus ();

  rotator_rr_scheduler #(
    .WIDTH(8), .SHIFTBITS_PER_STEP(1), .NUM_REQ(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.reqValid = 3'b000;
    bus.reqData  = '0;
    bus.reqRot   = '0;
    bus.outReady = 1'b1;
    tick();
    tick();
    bus.reqValid = 3'b111;
    #1;
    checks++;
    if (bus.reqReady !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected %b", bus.reqReady, 3'b000); end
    checks++;
    if (bus.outValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected %b", bus.outValid, 1'b0); end
    checks++;
    if (bus.outData !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected %h", bus.outData, 8'h00); end
    checks++;
    if (bus.outId !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected %0d", bus.outId, 0); end
    bus.reqValid = 3'b000;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.reqData[0] = 8'hB4;
    bus.reqRot[0]  = 3'd3;
    bus.reqValid   = 3'b001;
    bus.outReady   = 1'b1;
    #1;
    checks++;
    if (bus.reqReady !== 3'b001) begin errors++; $display("FAIL single_ready: got %b expected %b", bus.reqReady, 3'b001); end
    tick();
    bus.reqValid = 3'b000;
    checks++;
    if (bus.outValid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected %b", bus.outValid, 1'b1); end
    checks++;
    if (bus.outData !== 8'h96) begin errors++; $display("FAIL single_data: got %h expected %h", bus.outData, 8'h96); end
    checks++;
    if (bus.outId !== 2'd0) begin errors++; $display("FAIL single_id: got %0d expected %0d", bus.outId, 0); end
    tick();
    checks++;
    if (bus.outValid !== 1'b0) begin errors++; $display("FAIL single_drain_valid: got %b expected %b", bus.outValid, 1'b0); end
    checks++;
    if (bus.outData !== 8'h96) begin errors++; $display("FAIL single_drain_hold: got %h expected %h", bus.outData, 8'h96); end
  endtask

  // Last grant was 0, so the rotation starts at requester 1.
  task automatic test_round_robin();
    int         exp_ids [6] = '{1, 2, 0, 1, 2, 0};
    logic [7:0] exp_data [3] = '{8'h5A, 8'h02, 8'h0F};
    logic [2:0] exp_ready;
    bus.reqData[0] = 8'h5A; bus.reqRot[0] = 3'd0;
    bus.reqData[1] = 8'h01; bus.reqRot[1] = 3'd7;
    bus.reqData[2] = 8'hF0; bus.reqRot[2] = 3'd4;
    bus.reqValid   = 3'b111;
    bus.outReady   = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      exp_ready = 3'b001 << exp_ids[i];
      checks++;
      if (bus.reqReady !== exp_ready) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, bus.reqReady, exp_ready); end
      tick();
      checks++;
      if (bus.outValid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b expected %b", i, bus.outValid, 1'b1); end
      checks++;
      if (bus.outId !== 2'(exp_ids[i])) begin errors++; $display("FAIL rr_id[%0d]: got %0d expected %0d", i, bus.outId, exp_ids[i]); end
      checks++;
      if (bus.outData !== exp_data[exp_ids[i]]) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", i, bus.outData, exp_data[exp_ids[i]]); end
    end
  endtask

  task automatic test_stall();
    bus.outReady = 1'b0;
    #1;
    checks++;
    if (bus.reqReady !== 3'b000) begin errors++; $display("FAIL stall_ready0: got %b expected %b", bus.reqReady, 3'b000); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.outValid !== 1'b1 || bus.outId !== 2'd0 || bus.outData !== 8'h5A) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b id=%0d d=%h expected v=1 id=0 d=5a", i, bus.outValid, bus.outId, bus.outData);
      end
      checks++;
      if (bus.reqReady !== 3'b000) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected %b", i, bus.reqReady, 3'b000); end
    end
    bus.outReady = 1'b1;
    #1;
    checks++;
    if (bus.reqReady !== 3'b010) begin errors++; $display("FAIL stall_release_ready: got %b expected %b", bus.reqReady, 3'b010); end
    tick();
    checks++;
    if (bus.outId !== 2'd1 || bus.outData !== 8'h02) begin errors++; $display("FAIL stall_release_out: got id=%0d d=%h expected id=1 d=02", bus.outId, bus.outData); end
    bus.reqValid = 3'b000;
    tick();
    checks++;
    if (bus.outValid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b expected %b", bus.outValid, 1'b0); end
  endtask

  task automatic test_skip_idle();
    bus.reqValid = 3'b100;
    #1;
    checks++;
    if (bus.reqReady !== 3'b100) begin errors++; $display("FAIL skip_ready2: got %b expected %b", bus.reqReady, 3'b100); end
    tick();
    checks++;
    if (bus.outId !== 2'd2 || bus.outData !== 8'h0F) begin errors++; $display("FAIL skip_out2: got id=%0d d=%h expected id=2 d=0f", bus.outId, bus.outData); end
    bus.reqValid = 3'b110;
    #1;
    checks++;
    if (bus.reqReady !== 3'b010) begin errors++; $display("FAIL skip_ready1: got %b expected %b", bus.reqReady, 3'b010); end
    tick();
    checks++;
    if (bus.outId !== 2'd1 || bus.outData !== 8'h02) begin errors++; $display("FAIL skip_out1: got id=%0d d=%h expected id=1 d=02", bus.outId, bus.outData); end
    checks++;
    if (bus.reqReady !== 3'b100) begin errors++; $display("FAIL skip_ready2b: got %b expected %b", bus.reqReady, 3'b100); end
    tick();
    checks++;
    if (bus.outId !== 2'd2 || bus.outData !== 8'h0F) begin errors++; $display("FAIL skip_out2b: got id=%0d d=%h expected id=2 d=0f", bus.outId, bus.outData); end
    bus.reqValid = 3'b000;
    tick();
  endtask

  // Pointer is left at 1 before reset; without reset the next grant would be 2.
  task automatic test_reset_mid();
    bus.reqValid = 3'b111;
    bus.outReady = 1'b1;
    #1;
    tick();
    tick();
    checks++;
    if (bus.outValid !== 1'b1 || bus.outId !== 2'd1) begin errors++; $display("FAIL mid_pre: got v=%b id=%0d expected v=1 id=1", bus.outValid, bus.outId); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.outValid !== 1'b0) begin errors++; $display("FAIL mid_valid_drop: got %b expected %b", bus.outValid, 1'b0); end
    checks++;
    if (bus.outData !== 8'h00 || bus.reqReady !== 3'b000) begin errors++; $display("FAIL mid_clear: got d=%h rdy=%b expected d=00 rdy=000", bus.outData, bus.reqReady); end
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.reqReady !== 3'b001) begin errors++; $display("FAIL mid_first_ready: got %b expected %b", bus.reqReady, 3'b001); end
    tick();
    checks++;
    if (bus.outValid !== 1'b1 || bus.outId !== 2'd0 || bus.outData !== 8'h5A) begin
      errors++;
      $display("FAIL mid_first_out: got v=%b id=%0d d=%h expected v=1 id=0 d=5a", bus.outValid, bus.outId, bus.outData);
    end
    bus.reqValid = 3'b000;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_skip_idle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
